// File: rtl/tinysnn_pkg.sv
// Shared constants and slot-state encoding for the spike reset scheduler.
package tinysnn_pkg;

  localparam int N_NEURON  = 8;
  localparam int ID_W      = 3;
  localparam int RST_DELAY = 5;

  // Refractory counter width covers the largest legal delay (15).
  localparam int CNT_W     = 4;

  // Drop counter width and its saturation ceiling.
  localparam int DROP_W    = 8;
  localparam int DROP_MAX  = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_GRANT,
    S_REFR,
    S_CLR
  } slot_state_e;

endpackage

// File: rtl/spike_reset_scheduler_neuron_slot.sv
// One neuron slot: event lifecycle FSM, refractory countdown and the
// registered active-low clear pulse for that neuron core.
module neuron_slot #(
  parameter int RST_DELAY = tinysnn_pkg::RST_DELAY
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_spike,
  input  logic i_grant,
  input  logic i_hs,
  output logic o_pend,
  output logic o_drop,
  output logic o_rst_n
);
  import tinysnn_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_DELAY - 1);

  slot_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_n_q, rst_n_d;

  // State, counter and clear-output registers; clear held low during reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
    end
  end

  // Next-state: spike -> pending -> granted -> refractory countdown -> clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (i_spike) state_d = S_PEND;
      S_PEND:  if (i_grant) state_d = S_GRANT;
      S_GRANT: if (i_hs) begin
                 state_d = S_REFR;
                 cnt_d   = CNT_LOAD;
               end
      S_REFR:  if (cnt_q == '0) state_d = S_CLR;
               else             cnt_d   = cnt_q - 1'b1;
      S_CLR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pending request, spike drop, and the clear level for the next cycle.
  always_comb begin
    o_pend  = (state_q == S_PEND);
    o_drop  = i_spike && (state_q != S_IDLE);
    rst_n_d = (state_d != S_CLR);
  end

  assign o_rst_n = rst_n_q;

endmodule

// File: rtl/spike_reset_scheduler.sv
// Spike reset scheduler: per-neuron slots, a round-robin arbiter feeding a
// single registered event port, and a saturating dropped-spike counter.
module spike_reset_scheduler #(
  parameter int N_NEURON  = tinysnn_pkg::N_NEURON,
  parameter int ID_W      = tinysnn_pkg::ID_W,
  parameter int RST_DELAY = tinysnn_pkg::RST_DELAY
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_NEURON-1:0] i_spike,
  output logic                o_evt_valid,
  output logic [ID_W-1:0]     o_evt_id,
  input  logic                i_evt_ready,
  output logic [N_NEURON-1:0] o_neuron_rst_n,
  output logic [7:0]          o_drop_cnt
);
  import tinysnn_pkg::*;

  logic                evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]     evt_id_q, evt_id_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [N_NEURON-1:0] pend_vec, drop_vec, grant_vec, hs_vec;
  logic                hs, load_en, found;
  logic [ID_W-1:0]     sel, cand;

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] base,
                                                input logic [N_NEURON-1:0] inc);
    int sum;
    sum = int'(base);
    for (int k = 0; k < N_NEURON; k++) begin
      if (inc[k]) sum = sum + 1;
    end
    return (sum > DROP_MAX) ? DROP_W'(DROP_MAX) : DROP_W'(sum);
  endfunction

  assign hs      = evt_valid_q & i_evt_ready;
  assign load_en = ~evt_valid_q | hs;

  for (genvar k = 0; k < N_NEURON; k++) begin : g_slot
    assign hs_vec[k] = hs && (evt_id_q == ID_W'(k));

    neuron_slot #(
      .RST_DELAY (RST_DELAY)
    ) u_slot (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_spike (i_spike[k]),
      .i_grant (grant_vec[k]),
      .i_hs    (hs_vec[k]),
      .o_pend  (pend_vec[k]),
      .o_drop  (drop_vec[k]),
      .o_rst_n (o_neuron_rst_n[k])
    );
  end

  // Round-robin pick starting after the last grant; loads only when the port frees up.
  always_comb begin
    found       = 1'b0;
    sel         = '0;
    cand        = '0;
    grant_vec   = '0;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    last_d      = last_q;
    for (int i = 1; i <= N_NEURON; i++) begin
      cand = ID_W'((int'(last_q) + i) % N_NEURON);
      if (!found && pend_vec[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    if (load_en) begin
      evt_valid_d = found;
      if (found) begin
        evt_id_d       = sel;
        last_d         = sel;
        grant_vec[sel] = 1'b1;
      end
    end
  end

  // Dropped spikes accumulate without wrapping.
  always_comb begin
    drop_cnt_d = sat_add(drop_cnt_q, drop_vec);
  end

  // Event port, round-robin pointer and drop counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      last_q      <= ID_W'(N_NEURON - 1);
      drop_cnt_q  <= '0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      last_q      <= last_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_evt_valid = evt_valid_q;
  assign o_evt_id    = evt_id_q;
  assign o_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_spike_reset_scheduler.sv
// Testbench for spike_reset_scheduler: timestamp-based reference model checked
// every cycle, plus hand-computed expectations at key points of each scenario.
module tb_spike_reset_scheduler;

  localparam int N = 8;
  localparam int D = 5;

  logic         clk = 1'b0;
  logic         i_rst;
  logic [N-1:0] i_spike;
  logic         i_evt_ready;
  logic         o_evt_valid;
  logic [2:0]   o_evt_id;
  logic [N-1:0] o_neuron_rst_n;
  logic [7:0]   o_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  spike_reset_scheduler #(
    .N_NEURON  (N),
    .ID_W      (3),
    .RST_DELAY (D)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_spike        (i_spike),
    .o_evt_valid    (o_evt_valid),
    .o_evt_id       (o_evt_id),
    .i_evt_ready    (i_evt_ready),
    .o_neuron_rst_n (o_neuron_rst_n),
    .o_drop_cnt     (o_drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a neuron is busy while waiting, while presented, and
  // from the handshake edge until one edge past its scheduled clear edge.
  int         cyc = 0;
  int         clr_at [N];
  bit         m_pend [N];
  bit         m_valid;
  int         m_id;
  int         m_last;
  int         m_drop;
  logic [N-1:0] m_rstn;
  bit         m_ok = 1'b0;

  task automatic model_step();
    bit hs;
    bit found;
    bit acc [N];
    int sel;
    int idx;
    cyc++;
    if (i_rst) begin
      for (int k = 0; k < N; k++) begin
        m_pend[k] = 1'b0;
        clr_at[k] = -100;
      end
      m_valid = 1'b0;
      m_id    = 0;
      m_last  = N - 1;
      m_drop  = 0;
      m_rstn  = '0;
      m_ok    = 1'b1;
      return;
    end
    hs = m_valid && i_evt_ready;
    for (int k = 0; k < N; k++) begin
      acc[k] = i_spike[k] && !(m_pend[k] || (m_valid && m_id == k) || (cyc <= clr_at[k] + 1));
      if (i_spike[k] && !acc[k] && m_drop < 255) m_drop++;
    end
    if (hs) clr_at[m_id] = cyc + D;
    if (!m_valid || hs) begin
      found = 1'b0;
      sel   = 0;
      for (int i = 1; i <= N; i++) begin
        idx = (m_last + i) % N;
        if (!found && m_pend[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
      m_valid = found;
      if (found) begin
        m_pend[sel] = 1'b0;
        m_id        = sel;
        m_last      = sel;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (acc[k]) m_pend[k] = 1'b1;
      m_rstn[k] = (clr_at[k] != cyc);
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (m_ok) begin
      n_tests++;
      if (o_evt_valid !== m_valid || (m_valid && o_evt_id !== 3'(m_id)) ||
          o_neuron_rst_n !== m_rstn || o_drop_cnt !== 8'(m_drop)) begin
        n_fail++;
        $display("FAIL cycle_check cyc=%0d dut/model: valid %0b/%0b id %0d/%0d rst_n %h/%h drop %0d/%0d",
                 cyc, o_evt_valid, m_valid, o_evt_id, m_id, o_neuron_rst_n, m_rstn,
                 o_drop_cnt, m_drop);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] sp, input logic rdy);
    i_spike     = sp;
    i_evt_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step('0, 1'b1);
    step('0, 1'b1);
    i_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst       = 1'b1;
    i_spike     = '0;
    i_evt_ready = 1'b1;
    @(negedge clk);

    // Single spike on neuron 2, clear pulse five edges after the handshake.
    do_reset();
    chk("reset_valid", o_evt_valid, 0);
    chk("reset_rst_n", o_neuron_rst_n, 0);
    chk("reset_drop", o_drop_cnt, 0);
    step(8'h04, 1'b1);
    chk("release_rst_n", o_neuron_rst_n, 8'hFF);
    chk("latency_valid_early", o_evt_valid, 0);
    step('0, 1'b1);
    chk("latency_valid", o_evt_valid, 1);
    chk("latency_id", o_evt_id, 2);
    step('0, 1'b1);
    repeat (4) step('0, 1'b1);
    chk("pre_clear_rst_n", o_neuron_rst_n, 8'hFF);
    step('0, 1'b1);
    chk("clear_n2_rst_n", o_neuron_rst_n, 8'hFB);
    step('0, 1'b1);
    chk("post_clear_rst_n", o_neuron_rst_n, 8'hFF);

    // Simultaneous spikes on 0, 3, 7 then 0 and 7 after the pointer sits at 7.
    do_reset();
    step(8'h89, 1'b1);
    step('0, 1'b1);
    chk("rr_first", o_evt_id, 0);
    step('0, 1'b1);
    chk("rr_second", o_evt_id, 3);
    step('0, 1'b1);
    chk("rr_third", o_evt_id, 7);
    step('0, 1'b1);
    chk("rr_empty_valid", o_evt_valid, 0);
    repeat (12) step('0, 1'b1);
    step(8'h81, 1'b1);
    step('0, 1'b1);
    chk("rr_wrap_first", o_evt_id, 0);
    step('0, 1'b1);
    chk("rr_wrap_second", o_evt_id, 7);

    // Stall with id 4 presented; three repeat spikes on neuron 4 are dropped.
    do_reset();
    step(8'h10, 1'b0);
    step('0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step((i % 3 == 2) ? 8'h10 : 8'h00, 1'b0);
      if (o_evt_valid !== 1'b1 || o_evt_id !== 3'd4) begin
        chk("stall_stable", {o_evt_valid, o_evt_id}, {1'b1, 3'd4});
      end
    end
    chk("stall_valid", o_evt_valid, 1);
    chk("stall_id", o_evt_id, 4);
    chk("stall_drop", o_drop_cnt, 3);
    step('0, 1'b1);
    chk("stall_release_valid", o_evt_valid, 0);

    // Spikes on neuron 1 during refractory and clear are dropped; next one lands.
    do_reset();
    step(8'h02, 1'b1);
    step('0, 1'b1);
    step('0, 1'b1);
    step('0, 1'b1);
    step(8'h02, 1'b1);
    repeat (2) step('0, 1'b1);
    step('0, 1'b1);
    chk("refr_clear_rst_n", o_neuron_rst_n, 8'hFD);
    step(8'h02, 1'b1);
    chk("refr_drop", o_drop_cnt, 2);
    step(8'h02, 1'b1);
    step('0, 1'b1);
    chk("after_clr_valid", o_evt_valid, 1);
    chk("after_clr_id", o_evt_id, 1);
    chk("after_clr_drop", o_drop_cnt, 2);

    // All neurons spiking every cycle saturate the drop counter.
    do_reset();
    repeat (40) step(8'hFF, 1'b1);
    chk("sat_drop", o_drop_cnt, 255);
    repeat (5) step('0, 1'b1);
    chk("sat_hold", o_drop_cnt, 255);

    // Reset while neuron 5 is refractory cancels its pending clear pulse.
    do_reset();
    step(8'h20, 1'b1);
    step('0, 1'b1);
    step('0, 1'b1);
    step('0, 1'b1);
    i_rst = 1'b1;
    step('0, 1'b1);
    chk("midrst_rst_n", o_neuron_rst_n, 0);
    chk("midrst_valid", o_evt_valid, 0);
    step('0, 1'b1);
    i_rst = 1'b0;
    step('0, 1'b1);
    chk("midrst_release_rst_n", o_neuron_rst_n, 8'hFF);
    repeat (10) step('0, 1'b1);
    chk("midrst_no_pulse", o_neuron_rst_n, 8'hFF);
    chk("midrst_valid_after", o_evt_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
